// File: rtl/pong_pkg.sv
// Shared constants for the pong front end: clocking, debounce timing,
// button indices and the per-channel debounce state encoding.
package pong_pkg;

    localparam int CLK_HZ          = 25_175_000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEBOUNCE_CNT_W  = 18;

    localparam int BTN_UP_P1   = 0;
    localparam int BTN_DOWN_P1 = 1;
    localparam int BTN_UP_P2   = 2;
    localparam int BTN_DOWN_P2 = 3;

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'b00,
        ST_CONFIRM_PRESS   = 2'b01,
        ST_PRESSED         = 2'b10,
        ST_CONFIRM_RELEASE = 2'b11
    } btn_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter and a
// four-state accept FSM producing a clean level plus press/release pulses.
module debounce_channel
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = pong_pkg::DEBOUNCE_CYCLES,
    parameter int CNT_W           = pong_pkg::DEBOUNCE_CNT_W
) (
    input  logic clk_0,
    input  logic rst,
    input  logic btn_n_raw,
    output logic btn_n_db,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("debounce_channel: DEBOUNCE_CYCLES does not fit in CNT_W");
    end

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Next-state logic; synchronous reset folded in so every flop has one source.
    always_comb begin
        s1_d      = btn_n_raw;
        s2_d      = s1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        db_d      = db_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (!rst) begin
            s1_d    = 1'b1;
            s2_d    = 1'b1;
            state_d = ST_RELEASED;
            cnt_d   = '0;
            db_d    = 1'b1;
        end else begin
            case (state_q)
                ST_RELEASED: begin
                    if (!s2_q) begin
                        state_d = ST_CONFIRM_PRESS;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                ST_CONFIRM_PRESS: begin
                    if (s2_q) begin
                        state_d = ST_RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                        db_d    = 1'b0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (s2_q) begin
                        state_d = ST_CONFIRM_RELEASE;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                ST_CONFIRM_RELEASE: begin
                    if (!s2_q) begin
                        state_d   = ST_PRESSED;
                        cnt_d     = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d   = ST_RELEASED;
                        cnt_d     = '0;
                        db_d      = 1'b1;
                        release_d = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_0) begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        db_q      <= db_d;
        press_q   <= press_d;
        release_q <= release_d;
    end

    assign btn_n_db      = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw active-low player buttons: one independent debounce
// channel per button, outputs gathered into buses for pong_logic.
module button_conditioner
    import pong_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = pong_pkg::DEBOUNCE_CYCLES,
    parameter int CNT_W           = pong_pkg::DEBOUNCE_CNT_W
) (
    input  logic             clk_0,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n_raw,
    output logic [N_BTN-1:0] btn_n_db,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk_0         (clk_0),
            .rst           (rst),
            .btn_n_raw     (btn_n_raw[i]),
            .btn_n_db      (btn_n_db[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios followed by
// random button activity, all compared against a run-length reference model.
module tb_button_conditioner;

    localparam int DB = 8;

    logic       clk_0 = 1'b0;
    logic       rst;
    logic [3:0] btn_n_raw;
    logic [3:0] btn_n_db;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 2-cycle input delay, then per channel a count of
    // consecutive samples disagreeing with the accepted level.
    logic [3:0] m_s1, m_s2, m_db, m_press, m_rel;
    int         m_run [4];

    button_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
    ) dut (
        .clk_0         (clk_0),
        .rst           (rst),
        .btn_n_raw     (btn_n_raw),
        .btn_n_db      (btn_n_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk_0 = ~clk_0;

    task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task model_edge(input logic [3:0] raw, input logic r);
        logic [3:0] samp;
        m_press = 4'b0000;
        m_rel   = 4'b0000;
        if (!r) begin
            m_s1 = 4'b1111;
            m_s2 = 4'b1111;
            m_db = 4'b1111;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
        end else begin
            samp = m_s2;
            m_s2 = m_s1;
            m_s1 = raw;
            for (int c = 0; c < 4; c++) begin
                if (samp[c] != m_db[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_db[c]  = samp[c];
                        m_run[c] = 0;
                        if (samp[c] == 1'b0) m_press[c] = 1'b1;
                        else                 m_rel[c]   = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    endtask

    // Apply inputs, clock once, advance the model, check all outputs.
    task tick(input logic [3:0] raw, input logic r);
        btn_n_raw = raw;
        rst       = r;
        @(posedge clk_0);
        model_edge(raw, r);
        @(negedge clk_0);
        check("btn_n_db", {28'd0, btn_n_db}, {28'd0, m_db});
        check("press_pulse", {28'd0, press_pulse}, {28'd0, m_press});
        check("release_pulse", {28'd0, release_pulse}, {28'd0, m_rel});
    endtask

    task settle_released();
        for (int k = 0; k < 20; k++) tick(4'b1111, 1'b1);
        check("released_idle", {28'd0, btn_n_db}, 32'h0000_000F);
    endtask

    logic [3:0] raw_r;
    int         hold [4];
    int         seen;

    initial begin
        rst       = 1'b0;
        btn_n_raw = 4'b1111;

        // 1: reset hold with buttons down, then qualify all four together
        for (int k = 0; k < 3; k++) tick(4'b0000, 1'b0);
        check("t1_reset_db", {28'd0, btn_n_db}, 32'h0000_000F);
        check("t1_reset_press", {28'd0, press_pulse}, 32'h0000_0000);
        for (int e = 1; e <= 11; e++) begin
            tick(4'b0000, 1'b1);
            if (e == 9)  check("t1_press_e9", {28'd0, press_pulse}, 32'h0000_0000);
            if (e == 10) check("t1_press_e10", {28'd0, press_pulse}, 32'h0000_000F);
            if (e == 10) check("t1_db_e10", {28'd0, btn_n_db}, 32'h0000_0000);
            if (e == 11) check("t1_press_e11", {28'd0, press_pulse}, 32'h0000_0000);
        end
        settle_released();

        // 2: clean press on bit0
        for (int e = 1; e <= 11; e++) begin
            tick(4'b1110, 1'b1);
            if (e == 9)  check("t2_db_e9", {28'd0, btn_n_db}, 32'h0000_000F);
            if (e == 10) check("t2_press_e10", {28'd0, press_pulse}, 32'h0000_0001);
            if (e == 10) check("t2_db_e10", {28'd0, btn_n_db}, 32'h0000_000E);
            if (e == 11) check("t2_press_e11", {28'd0, press_pulse}, 32'h0000_0000);
        end

        // 3: five-cycle glitch on bit2 is rejected
        seen = 0;
        for (int e = 1; e <= 20; e++) begin
            tick((e <= 5) ? 4'b1010 : 4'b1110, 1'b1);
            if (press_pulse[2] || release_pulse[2] || !btn_n_db[2]) seen++;
        end
        check("t3_glitch_activity", seen, 0);

        // 4: press bit3, then bouncy release
        for (int e = 0; e < 12; e++) tick(4'b0110, 1'b1);
        check("t4_bit3_pressed", {31'd0, btn_n_db[3]}, 32'd0);
        tick(4'b1110, 1'b1);
        tick(4'b0110, 1'b1);
        tick(4'b1110, 1'b1);
        tick(4'b0110, 1'b1);
        seen = 0;
        for (int e = 1; e <= 14; e++) begin
            tick(4'b1110, 1'b1);
            if (release_pulse[3]) seen++;
            if (e == 10) check("t4_release_e10", {31'd0, release_pulse[3]}, 32'd1);
        end
        check("t4_release_count", seen, 1);
        settle_released();

        // 5: reset in the middle of confirming bit1
        for (int e = 0; e < 6; e++) tick(4'b1101, 1'b1);
        tick(4'b1101, 1'b0);
        check("t5_reset_press", {28'd0, press_pulse}, 32'h0000_0000);
        for (int e = 1; e <= 11; e++) begin
            tick(4'b1101, 1'b1);
            if (e == 9)  check("t5_press_e9", {31'd0, press_pulse[1]}, 32'd0);
            if (e == 10) check("t5_press_e10", {31'd0, press_pulse[1]}, 32'd1);
        end
        settle_released();

        // 6: opposing buttons qualify in the same cycle
        for (int e = 1; e <= 10; e++) tick(4'b1100, 1'b1);
        check("t6_db", {30'd0, btn_n_db[1:0]}, 32'd0);
        check("t6_press", {30'd0, press_pulse[1:0]}, 32'd3);
        settle_released();

        // Random phase: per-channel random hold lengths around the threshold
        raw_r = 4'b1111;
        for (int c = 0; c < 4; c++) hold[c] = $urandom_range(1, 14);
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    raw_r[c] = ~raw_r[c];
                    hold[c]  = $urandom_range(1, 14);
                end else begin
                    hold[c]--;
                end
            end
            tick(raw_r, ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
